abacus_cache_profiler: RTL and testbench
========================================

# abacus_cache_profiler

Cache event counting unit of the ABACUS profiler. It takes raw per-cycle I-cache and D-cache event strobes from the host core, plus the profile-enable bit from the ABACUS register file. It produces saturating 32-bit request, hit, miss and line-fill-latency counters, and maximum-single-fill-latency registers, which the bus interface exposes as read-only registers. It sits directly downstream of the core's cache event taps and upstream of the ABACUS register read mux.

## Interface
Parameters:
- COUNTER_WIDTH, 32, width of every counter and latency register.

Ports:
- clk  in  1  system clock; all logic on rising edge. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  counting enable (bit 0 of cache profile enable register).
- clear  in  1  single-cycle synchronous clear of all counters.
- icache_request  in  1  I-cache lookup this cycle.
- icache_miss  in  1  I-cache lookup missed; qualified by icache_request in the same cycle.
- icache_line_fill_in_progress  in  1  I-cache refill active (level).
- dcache_request  in  1  D-cache lookup this cycle.
- dcache_hit  in  1  D-cache lookup hit; qualified by dcache_request in the same cycle.
- dcache_line_fill_in_progress  in  1  D-cache refill active (level).
- icache_request_counter, icache_hit_counter, icache_miss_counter  out  COUNTER_WIDTH  I-cache event counts.
- icache_line_fill_latency_counter  out  COUNTER_WIDTH  cumulative enabled I-cache fill cycles.
- icache_max_fill_latency  out  COUNTER_WIDTH  longest single I-cache fill, in enabled cycles.
- dcache_* (same five outputs)  out  COUNTER_WIDTH  D-cache equivalents.
- overflow  out  2  sticky flags; bit 0 = any I-cache counter saturated, bit 1 = any D-cache counter saturated.

## Operation
- Every output is a register. Reset value of all counters, max registers and overflow is 0. Fill FSMs reset to IDLE.
- Event decode:
  - I-cache: hit = request & ~miss; miss = request & miss.
  - D-cache: hit = request & hit; miss = request & ~hit.
  - A miss/hit input without request is ignored.
- Counting happens only while enable=1. When enable=0, counters hold their values.
- Saturation: a counter at all-ones stays all-ones on further increment and sets its lane's overflow bit. Overflow clears only on rst or clear.
- clear has priority over increment in the same cycle. After clear, counters, max registers and overflow are 0, and the current-fill length is 0. The FSM state is untouched.
- Fill FSM, per lane:
  - IDLE -> FILL when fill_in_progress=1. This is level-sensitive, so a fill spanning reset is tracked from the first post-reset cycle.
  - In FILL, each cycle with fill_in_progress=1: cur_len increments (saturating) if enable; the latency counter increments if enable.
  - FILL -> IDLE when fill_in_progress=0. On that cycle, max <= max(max, cur_len) and cur_len <= 0.
  - The max update is not gated by enable. A back-to-back fill needs one low cycle to be seen as a new fill.
- Request, hit, miss and latency increments within a lane are independent and may all occur in the same cycle. The two lanes are fully independent.

## Timing
- An event sampled at edge N is visible on the counter output after edge N (1-cycle latency). There is no combinational path from inputs to outputs.
- A max update is visible the cycle after fill_in_progress is first seen low.
- A fill of K cycles with enable held high adds exactly K to the latency counter and yields cur_len=K.
- rst asserted mid-fill: the FSM goes to IDLE and cur_len goes to 0 on that edge. Fill cycles before reset are lost.
- enable dropped mid-fill: accumulation pauses and the fill stays tracked. The max uses the enabled cycles only.

## Structure
- The shared package abacus_pkg holds COUNTER_WIDTH default and fill_state_t (IDLE, FILL).
- The shared package also holds a saturating-increment function used by all counters.
- Sub-module abacus_cache_lane: one lane containing request/hit/miss counters, the fill FSM, the latency counter and the max register. It is instantiated twice.
  - The parameter HIT_POLARITY selects whether the qualifier input is a miss (I-cache) or a hit (D-cache).
- The top-level module only maps ports and concatenates the overflow bits.

## Test plan
- Reset, enable=1, 10 icache_request cycles with miss high on 3 of them -> request=10, hit=7, miss=3; D-cache counters stay 0.
- enable=1, dcache_line_fill_in_progress high 5 cycles, low 1 cycle, high 8 cycles, then low -> dcache latency=13, dcache max=8, two FSM IDLE->FILL transitions.
- Load icache_request_counter to 0xFFFFFFFE via forced request stream (or a COUNTER_WIDTH=4 build: 15 requests, then 2 more), then keep requesting -> counter sticks at all-ones and overflow[0]=1; clear -> all 0 and overflow=0.
- clear and icache_request asserted in the same cycle with counter at 5 -> counter 0 next cycle, not 1.
- Fill high 10 cycles with enable dropped for cycles 4-6 -> latency=7, max=7; counters hold during the disabled window.
- rst pulsed on cycle 3 of a 6-cycle I-cache fill with in_progress held high -> post-reset latency=3, max=3 after the fill ends.

Source files
------------

// File: rtl/abacus_pkg.sv
// Shared definitions for the ABACUS cache profiler.
//   COUNTER_WIDTH_DEFAULT : default width of every counter and latency register
//   fill_state_t          : per-lane line-fill tracking state
//   sat_inc()             : saturating increment shared by all counters
package abacus_pkg;

  localparam int unsigned COUNTER_WIDTH_DEFAULT = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Saturating increment for counters up to 64 bits wide. The caller passes its
  // zero-extended value and real width, then casts the result back down.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/abacus_cache_lane.sv
// One cache lane of the ABACUS profiler: request/hit/miss counters, the
// line-fill FSM, the cumulative fill-latency counter and the longest-fill register.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   enable                   : counting enable
//   clear                    : synchronous clear of counters, max, overflow, current fill length
//   request                  : cache lookup this cycle
//   qualifier                : miss (HIT_POLARITY=0) or hit (HIT_POLARITY=1), gated by request
//   fill_in_progress         : refill active (level)
//   request/hit/miss_counter : saturating event counts
//   fill_latency_counter     : cumulative enabled fill cycles
//   max_fill_latency         : longest single fill in enabled cycles
//   overflow                 : sticky, set when any counter increments while at all-ones
module abacus_cache_lane
  import abacus_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT,
  parameter bit          HIT_POLARITY  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     request,
  input  logic                     qualifier,
  input  logic                     fill_in_progress,
  output logic [COUNTER_WIDTH-1:0] request_counter,
  output logic [COUNTER_WIDTH-1:0] hit_counter,
  output logic [COUNTER_WIDTH-1:0] miss_counter,
  output logic [COUNTER_WIDTH-1:0] fill_latency_counter,
  output logic [COUNTER_WIDTH-1:0] max_fill_latency,
  output logic                     overflow
);

  fill_state_t state_q, state_d;

  logic [COUNTER_WIDTH-1:0] req_q, req_d;
  logic [COUNTER_WIDTH-1:0] hit_q, hit_d;
  logic [COUNTER_WIDTH-1:0] miss_q, miss_d;
  logic [COUNTER_WIDTH-1:0] lat_q, lat_d;
  logic [COUNTER_WIDTH-1:0] max_q, max_d;
  logic [COUNTER_WIDTH-1:0] cur_q, cur_d;
  logic                     ovf_q, ovf_d;

  logic hit_event;
  logic miss_event;

  function automatic logic [COUNTER_WIDTH-1:0] inc(input logic [COUNTER_WIDTH-1:0] value);
    return COUNTER_WIDTH'(sat_inc(64'(value), COUNTER_WIDTH));
  endfunction

  // A qualifier without a request carries no meaning and is dropped here.
  always_comb begin
    if (HIT_POLARITY) begin
      hit_event  = request & qualifier;
      miss_event = request & ~qualifier;
    end else begin
      hit_event  = request & ~qualifier;
      miss_event = request & qualifier;
    end
  end

  // Level-sensitive so a fill already underway when reset releases is picked up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_in_progress)  state_d = FILL;
      FILL:    if (!fill_in_progress) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d  = req_q;
    hit_d  = hit_q;
    miss_d = miss_q;
    lat_d  = lat_q;
    max_d  = max_q;
    cur_d  = cur_q;
    ovf_d  = ovf_q;

    if (enable) begin
      if (request) begin
        req_d = inc(req_q);
        if (&req_q) ovf_d = 1'b1;
      end
      if (hit_event) begin
        hit_d = inc(hit_q);
        if (&hit_q) ovf_d = 1'b1;
      end
      if (miss_event) begin
        miss_d = inc(miss_q);
        if (&miss_q) ovf_d = 1'b1;
      end
      // The first high cycle (still IDLE) is counted too, so a K-cycle fill adds K.
      if (fill_in_progress) begin
        lat_d = inc(lat_q);
        cur_d = inc(cur_q);
        if (&lat_q) ovf_d = 1'b1;
      end
    end

    // End of fill: max tracking is deliberately not gated by enable.
    if (state_q == FILL && !fill_in_progress) begin
      if (cur_q > max_q) max_d = cur_q;
      cur_d = '0;
    end

    // Clear wins over any increment; the FSM keeps tracking.
    if (clear) begin
      req_d  = '0;
      hit_d  = '0;
      miss_d = '0;
      lat_d  = '0;
      max_d  = '0;
      cur_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      lat_q   <= '0;
      max_q   <= '0;
      cur_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      lat_q   <= lat_d;
      max_q   <= max_d;
      cur_q   <= cur_d;
      ovf_q   <= ovf_d;
    end
  end

  assign request_counter      = req_q;
  assign hit_counter          = hit_q;
  assign miss_counter         = miss_q;
  assign fill_latency_counter = lat_q;
  assign max_fill_latency     = max_q;
  assign overflow             = ovf_q;

endmodule

// File: rtl/abacus_cache_profiler.sv
// ABACUS cache event counting unit: an I-cache lane and a D-cache lane.
// Ports:
//   clk, rst, enable, clear           : clock, sync reset, counting enable, sync clear
//   icache_request/miss/line_fill_*   : I-cache event taps (qualifier is a miss)
//   dcache_request/hit/line_fill_*    : D-cache event taps (qualifier is a hit)
//   icache_* / dcache_* counters      : registered, saturating counters and max-fill registers
//   overflow                          : {dcache lane saturated, icache lane saturated}, sticky
module abacus_cache_profiler
  import abacus_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     icache_request,
  input  logic                     icache_miss,
  input  logic                     icache_line_fill_in_progress,
  input  logic                     dcache_request,
  input  logic                     dcache_hit,
  input  logic                     dcache_line_fill_in_progress,
  output logic [COUNTER_WIDTH-1:0] icache_request_counter,
  output logic [COUNTER_WIDTH-1:0] icache_hit_counter,
  output logic [COUNTER_WIDTH-1:0] icache_miss_counter,
  output logic [COUNTER_WIDTH-1:0] icache_line_fill_latency_counter,
  output logic [COUNTER_WIDTH-1:0] icache_max_fill_latency,
  output logic [COUNTER_WIDTH-1:0] dcache_request_counter,
  output logic [COUNTER_WIDTH-1:0] dcache_hit_counter,
  output logic [COUNTER_WIDTH-1:0] dcache_miss_counter,
  output logic [COUNTER_WIDTH-1:0] dcache_line_fill_latency_counter,
  output logic [COUNTER_WIDTH-1:0] dcache_max_fill_latency,
  output logic [1:0]               overflow
);

  logic icache_overflow;
  logic dcache_overflow;

  abacus_cache_lane #(
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .HIT_POLARITY (1'b0)
  ) u_icache_lane (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .clear               (clear),
    .request             (icache_request),
    .qualifier           (icache_miss),
    .fill_in_progress    (icache_line_fill_in_progress),
    .request_counter     (icache_request_counter),
    .hit_counter         (icache_hit_counter),
    .miss_counter        (icache_miss_counter),
    .fill_latency_counter(icache_line_fill_latency_counter),
    .max_fill_latency    (icache_max_fill_latency),
    .overflow            (icache_overflow)
  );

  abacus_cache_lane #(
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .HIT_POLARITY (1'b1)
  ) u_dcache_lane (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .clear               (clear),
    .request             (dcache_request),
    .qualifier           (dcache_hit),
    .fill_in_progress    (dcache_line_fill_in_progress),
    .request_counter     (dcache_request_counter),
    .hit_counter         (dcache_hit_counter),
    .miss_counter        (dcache_miss_counter),
    .fill_latency_counter(dcache_line_fill_latency_counter),
    .max_fill_latency    (dcache_max_fill_latency),
    .overflow            (dcache_overflow)
  );

  assign overflow = {dcache_overflow, icache_overflow};

endmodule

// File: tb/tb_abacus_cache_profiler.sv
// Two DUTs share one stimulus stream: a default 32-bit build and a 4-bit build
// that reaches saturation quickly. Both are compared each cycle against a
// behavioural event-count model, plus directed scenario checks.
module tb_abacus_cache_profiler;

  logic clk = 1'b0;
  logic rst, enable, clear;
  logic ireq, imiss, ifill, dreq, dhit, dfill;

  logic [31:0] m0_ireq, m0_ihit, m0_imiss, m0_ilat, m0_imax;
  logic [31:0] m0_dreq, m0_dhit, m0_dmiss, m0_dlat, m0_dmax;
  logic [1:0]  m0_ovf;
  logic [3:0]  m1_ireq, m1_ihit, m1_imiss, m1_ilat, m1_imax;
  logic [3:0]  m1_dreq, m1_dhit, m1_dmiss, m1_dlat, m1_dmax;
  logic [1:0]  m1_ovf;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state indexed [dut][lane], lane 0 = I-cache, 1 = D-cache.
  longint cap [2];
  longint m_req [2][2];
  longint m_hit [2][2];
  longint m_miss[2][2];
  longint m_lat [2][2];
  longint m_max [2][2];
  longint m_cur [2][2];
  bit     m_in  [2][2];
  bit     m_ovf [2][2];

  always #5 clk = ~clk;

  abacus_cache_profiler u_dut32 (
    .clk                             (clk),
    .rst                             (rst),
    .enable                          (enable),
    .clear                           (clear),
    .icache_request                  (ireq),
    .icache_miss                     (imiss),
    .icache_line_fill_in_progress    (ifill),
    .dcache_request                  (dreq),
    .dcache_hit                      (dhit),
    .dcache_line_fill_in_progress    (dfill),
    .icache_request_counter          (m0_ireq),
    .icache_hit_counter              (m0_ihit),
    .icache_miss_counter             (m0_imiss),
    .icache_line_fill_latency_counter(m0_ilat),
    .icache_max_fill_latency         (m0_imax),
    .dcache_request_counter          (m0_dreq),
    .dcache_hit_counter              (m0_dhit),
    .dcache_miss_counter             (m0_dmiss),
    .dcache_line_fill_latency_counter(m0_dlat),
    .dcache_max_fill_latency         (m0_dmax),
    .overflow                        (m0_ovf)
  );

  abacus_cache_profiler #(.COUNTER_WIDTH(4)) u_dut4 (
    .clk                             (clk),
    .rst                             (rst),
    .enable                          (enable),
    .clear                           (clear),
    .icache_request                  (ireq),
    .icache_miss                     (imiss),
    .icache_line_fill_in_progress    (ifill),
    .dcache_request                  (dreq),
    .dcache_hit                      (dhit),
    .dcache_line_fill_in_progress    (dfill),
    .icache_request_counter          (m1_ireq),
    .icache_hit_counter              (m1_ihit),
    .icache_miss_counter             (m1_imiss),
    .icache_line_fill_latency_counter(m1_ilat),
    .icache_max_fill_latency         (m1_imax),
    .dcache_request_counter          (m1_dreq),
    .dcache_hit_counter              (m1_dhit),
    .dcache_miss_counter             (m1_dmiss),
    .dcache_line_fill_latency_counter(m1_dlat),
    .dcache_max_fill_latency         (m1_dmax),
    .overflow                        (m1_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input int d, input int l, input longint c);
    if (c >= cap[d]) begin
      m_ovf[d][l] = 1'b1;
      return c;
    end
    return c + 1;
  endfunction

  // One clock of the event-count rules, applied to the inputs seen at the edge.
  task automatic model_cycle();
    bit r[2];
    bit q[2];
    bit f[2];
    r[0] = ireq; q[0] = imiss; f[0] = ifill;
    r[1] = dreq; q[1] = dhit;  f[1] = dfill;
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 2; l++) begin
        bit hit_e, miss_e;
        hit_e  = r[l] && ((l == 0) ? !q[l] : q[l]);
        miss_e = r[l] && !hit_e;
        if (rst) begin
          m_req[d][l] = 0; m_hit[d][l] = 0; m_miss[d][l] = 0;
          m_lat[d][l] = 0; m_max[d][l] = 0; m_cur[d][l] = 0;
          m_ovf[d][l] = 0; m_in[d][l] = 0;
        end else begin
          if (clear) begin
            m_req[d][l] = 0; m_hit[d][l] = 0; m_miss[d][l] = 0;
            m_lat[d][l] = 0; m_max[d][l] = 0; m_cur[d][l] = 0;
            m_ovf[d][l] = 0;
          end else begin
            if (enable) begin
              if (r[l])   m_req[d][l]  = sat(d, l, m_req[d][l]);
              if (hit_e)  m_hit[d][l]  = sat(d, l, m_hit[d][l]);
              if (miss_e) m_miss[d][l] = sat(d, l, m_miss[d][l]);
              if (f[l]) begin
                m_lat[d][l] = sat(d, l, m_lat[d][l]);
                if (m_cur[d][l] < cap[d]) m_cur[d][l] = m_cur[d][l] + 1;
              end
            end
            if (!f[l] && m_in[d][l]) begin
              if (m_cur[d][l] > m_max[d][l]) m_max[d][l] = m_cur[d][l];
              m_cur[d][l] = 0;
            end
          end
          m_in[d][l] = f[l];
        end
      end
    end
  endtask

  task automatic check_all();
    chk("d32_ireq",  m0_ireq,  32'(m_req[0][0]));
    chk("d32_ihit",  m0_ihit,  32'(m_hit[0][0]));
    chk("d32_imiss", m0_imiss, 32'(m_miss[0][0]));
    chk("d32_ilat",  m0_ilat,  32'(m_lat[0][0]));
    chk("d32_imax",  m0_imax,  32'(m_max[0][0]));
    chk("d32_dreq",  m0_dreq,  32'(m_req[0][1]));
    chk("d32_dhit",  m0_dhit,  32'(m_hit[0][1]));
    chk("d32_dmiss", m0_dmiss, 32'(m_miss[0][1]));
    chk("d32_dlat",  m0_dlat,  32'(m_lat[0][1]));
    chk("d32_dmax",  m0_dmax,  32'(m_max[0][1]));
    chk("d32_ovf",   {30'b0, m0_ovf}, {30'b0, m_ovf[0][1], m_ovf[0][0]});
    chk("d4_ireq",   {28'b0, m1_ireq},  32'(m_req[1][0]));
    chk("d4_ihit",   {28'b0, m1_ihit},  32'(m_hit[1][0]));
    chk("d4_imiss",  {28'b0, m1_imiss}, 32'(m_miss[1][0]));
    chk("d4_ilat",   {28'b0, m1_ilat},  32'(m_lat[1][0]));
    chk("d4_imax",   {28'b0, m1_imax},  32'(m_max[1][0]));
    chk("d4_dreq",   {28'b0, m1_dreq},  32'(m_req[1][1]));
    chk("d4_dhit",   {28'b0, m1_dhit},  32'(m_hit[1][1]));
    chk("d4_dmiss",  {28'b0, m1_dmiss}, 32'(m_miss[1][1]));
    chk("d4_dlat",   {28'b0, m1_dlat},  32'(m_lat[1][1]));
    chk("d4_dmax",   {28'b0, m1_dmax},  32'(m_max[1][1]));
    chk("d4_ovf",    {30'b0, m1_ovf}, {30'b0, m_ovf[1][1], m_ovf[1][0]});
  endtask

  // Inputs are held across the edge; model and outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_cycle();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 0; clear = 0; enable = 1;
    ireq = 0; imiss = 0; ifill = 0;
    dreq = 0; dhit = 0; dfill = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    cap[0] = 64'hFFFF_FFFF;
    cap[1] = 15;
    idle_inputs();
    #1;

    // Reset state
    do_reset();
    chk("rst_ireq", m0_ireq, 32'd0);
    chk("rst_dmax", m0_dmax, 32'd0);
    chk("rst_ovf", {30'b0, m0_ovf}, 32'd0);

    // 10 I-cache requests, 3 of them missing
    for (int i = 0; i < 10; i++) begin
      ireq = 1;
      imiss = (i == 2 || i == 5 || i == 8);
      cycle();
    end
    ireq = 0; imiss = 0;
    chk("t1_ireq", m0_ireq, 32'd10);
    chk("t1_ihit", m0_ihit, 32'd7);
    chk("t1_imiss", m0_imiss, 32'd3);
    chk("t1_dreq", m0_dreq, 32'd0);

    // D-cache fills of 5 and 8 cycles separated by one low cycle
    do_reset();
    dfill = 1;
    repeat (5) cycle();
    dfill = 0;
    cycle();
    chk("t2_max_first", m0_dmax, 32'd5);
    dfill = 1;
    repeat (8) cycle();
    dfill = 0;
    cycle();
    chk("t2_dlat", m0_dlat, 32'd13);
    chk("t2_dmax", m0_dmax, 32'd8);

    // Saturation on the 4-bit build, then clear
    do_reset();
    ireq = 1;
    repeat (17) cycle();
    ireq = 0;
    chk("t3_sat_ireq", {28'b0, m1_ireq}, 32'd15);
    chk("t3_sat_ovf", {30'b0, m1_ovf}, 32'd1);
    chk("t3_wide_ireq", m0_ireq, 32'd17);
    clear = 1;
    cycle();
    clear = 0;
    chk("t3_clr_ireq", {28'b0, m1_ireq}, 32'd0);
    chk("t3_clr_ovf", {30'b0, m1_ovf}, 32'd0);

    // Clear beats a same-cycle request
    do_reset();
    ireq = 1;
    repeat (5) cycle();
    chk("t4_pre", m0_ireq, 32'd5);
    clear = 1;
    cycle();
    clear = 0;
    chk("t4_clear_wins", m0_ireq, 32'd0);
    cycle();
    ireq = 0;
    chk("t4_after", m0_ireq, 32'd1);

    // 10-cycle fill with enable low on cycles 4-6
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ifill = 1;
      ireq = 1;
      enable = !(i >= 3 && i <= 5);
      cycle();
      if (i == 4) chk("t5_hold_req", m0_ireq, 32'd3);
    end
    ifill = 0; ireq = 0; enable = 1;
    cycle();
    chk("t5_ilat", m0_ilat, 32'd7);
    chk("t5_imax", m0_imax, 32'd7);
    chk("t5_ireq", m0_ireq, 32'd7);

    // Reset on cycle 3 of a 6-cycle fill
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ifill = 1;
      rst = (i == 2);
      cycle();
    end
    rst = 0; ifill = 0;
    cycle();
    chk("t6_ilat", m0_ilat, 32'd3);
    chk("t6_imax", m0_imax, 32'd3);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      clear  = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 7) != 0);
      ireq   = $urandom_range(0, 1) == 1;
      imiss  = $urandom_range(0, 2) == 0;
      dreq   = $urandom_range(0, 1) == 1;
      dhit   = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 4) == 0) ifill = !ifill;
      if ($urandom_range(0, 4) == 0) dfill = !dfill;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
